// File: rtl/div_share_arbiter.sv
// ============================================================================
// Module   : div_share_arbiter
// Purpose  : Round-robin sharing of one pipelined divider among N_REQ
//            requesters. Issues one division per cycle, tracks in-flight
//            operations with a tag pipe matched to the divider latency, and
//            returns the truncated 20-bit quotient as a one-cycle strobe.
//            Divide-by-zero results are saturated to the numerator's sign.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 5
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [32*N_REQ-1:0]   req_num_i,
    input  logic [22*N_REQ-1:0]   req_den_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic [31:0]           div_num_o,
    output logic [21:0]           div_den_o,
    input  logic [19:0]           div_quot_i,
    output logic [N_REQ-1:0]      rsp_valid_o,
    output logic [19:0]           rsp_quot_o,
    output logic                  rsp_divz_o,
    output logic                  busy_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [19:0] C_QUOT_POS_SAT = 20'h7FFFF;
    localparam logic [19:0] C_QUOT_NEG_SAT = 20'h80000;

    // Arbiter state
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             grant_found;
    logic [PTR_W-1:0] grant_id;
    logic [PTR_W-1:0] scan_idx;

    // Operands of the granted requester
    logic [31:0]      sel_num;
    logic [21:0]      sel_den;

    // Tag pipe, one entry per divider stage
    logic [LATENCY-1:0] tag_v_q,     tag_v_d;
    logic [LATENCY-1:0] tag_divz_q,  tag_divz_d;
    logic [LATENCY-1:0] tag_nsign_q, tag_nsign_d;
    logic [PTR_W-1:0]   tag_id_q [LATENCY];
    logic [PTR_W-1:0]   tag_id_d [LATENCY];

    // Response register
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [19:0]      rsp_quot_q,  rsp_quot_d;
    logic             rsp_divz_q,  rsp_divz_d;

    // Round-robin search: scan offsets from the far end so the offset closest
    // to rr_ptr is written last and wins. No grant during flush or reset.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (req_valid_i[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
        if (flush_i || reset_i) begin
            grant_found = 1'b0;
        end
    end

    // One-hot ready and operand mux; idle divider sees 0/1 so it never divides by zero
    always_comb begin
        req_ready_o = '0;
        sel_num     = '0;
        sel_den     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == PTR_W'(i)) begin
                sel_num = req_num_i[32*i +: 32];
                sel_den = req_den_i[22*i +: 22];
            end
            req_ready_o[i] = grant_found && (grant_id == PTR_W'(i));
        end
        div_num_o = grant_found ? sel_num : 32'd0;
        div_den_o = grant_found ? sel_den : 22'd1;
    end

    // Pointer advances past the winner only when something was granted
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_found) begin
            rr_ptr_d = PTR_W'((int'(grant_id) + 1) % N_REQ);
        end
    end

    // Tag pipe next state: load stage 0 from the grant, shift the rest, flush clears valids
    always_comb begin
        tag_v_d[0]     = grant_found;
        tag_id_d[0]    = grant_id;
        tag_divz_d[0]  = grant_found && (sel_den == 22'd0);
        tag_nsign_d[0] = sel_num[31];
        for (int s = 1; s < LATENCY; s++) begin
            tag_v_d[s]     = tag_v_q[s-1];
            tag_id_d[s]    = tag_id_q[s-1];
            tag_divz_d[s]  = tag_divz_q[s-1];
            tag_nsign_d[s] = tag_nsign_q[s-1];
        end
        if (flush_i) begin
            tag_v_d = '0;
        end
    end

    // Response next state: capture the divider output for the retiring tag
    always_comb begin
        rsp_valid_d = '0;
        rsp_quot_d  = rsp_quot_q;
        rsp_divz_d  = rsp_divz_q;
        if (tag_v_q[LATENCY-1] && !flush_i) begin
            rsp_valid_d[tag_id_q[LATENCY-1]] = 1'b1;
            rsp_divz_d = tag_divz_q[LATENCY-1];
            if (tag_divz_q[LATENCY-1]) begin
                rsp_quot_d = tag_nsign_q[LATENCY-1] ? C_QUOT_NEG_SAT : C_QUOT_POS_SAT;
            end else begin
                rsp_quot_d = div_quot_i;
            end
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q    <= '0;
            tag_v_q     <= '0;
            tag_divz_q  <= '0;
            tag_nsign_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_quot_q  <= '0;
            rsp_divz_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tag_v_q     <= tag_v_d;
            tag_divz_q  <= tag_divz_d;
            tag_nsign_q <= tag_nsign_d;
            for (int s = 0; s < LATENCY; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_quot_q  <= rsp_quot_d;
            rsp_divz_q  <= rsp_divz_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_quot_o  = rsp_quot_q;
    assign rsp_divz_o  = rsp_divz_q;
    assign busy_o      = (|tag_v_q) || (|rsp_valid_q);

endmodule

`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
// ============================================================================
// Module   : tb_div_share_arbiter
// Purpose  : Directed self-checking bench for div_share_arbiter with a
//            5-stage behavioural divider model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_share_arbiter;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [3:0]   req_valid;
    logic [127:0] req_num;
    logic [87:0]  req_den;
    logic [3:0]   req_ready;
    logic [31:0]  div_num;
    logic [21:0]  div_den;
    logic [19:0]  div_quot;
    logic [3:0]   rsp_valid;
    logic [19:0]  rsp_quot;
    logic         rsp_divz;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    div_share_arbiter #(.N_REQ(4), .LATENCY(5)) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_num_i   (req_num),
        .req_den_i   (req_den),
        .req_ready_o (req_ready),
        .div_num_o   (div_num),
        .div_den_o   (div_den),
        .div_quot_i  (div_quot),
        .rsp_valid_o (rsp_valid),
        .rsp_quot_o  (rsp_quot),
        .rsp_divz_o  (rsp_divz),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural pipelined divider: operands sampled at an edge appear 5 edges later
    function automatic logic [19:0] model_div(input logic [31:0] n, input logic [21:0] d);
        logic signed [31:0] sn;
        logic signed [31:0] sd;
        logic signed [31:0] q;
        sn = $signed(n);
        sd = 32'($signed(d));
        if (sd == 0) return 20'h0;
        q = sn / sd;
        return q[19:0];
    endfunction

    logic [19:0] dpipe [5];
    always @(posedge clk) begin
        dpipe[0] <= model_div(div_num, div_den);
        for (int k = 1; k < 5; k++) dpipe[k] <= dpipe[k-1];
    end
    assign div_quot = dpipe[4];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Start of a cycle: just after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle within the cycle before sampling
    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int p, input logic [31:0] n, input logic [21:0] d);
        req_valid[p]         = 1'b1;
        req_num[32*p +: 32]  = n;
        req_den[22*p +: 22]  = d;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    logic [19:0] rr_exp [4];

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_num   = '0;
        req_den   = '0;
        for (int k = 0; k < 5; k++) dpipe[k] = '0;
        next_cycle();
        // Reset state, even with every port requesting
        req_valid = 4'b1111;
        settle();
        check_eq("reset_ready", 32'(req_ready), 32'h0);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("reset_rsp_quot", 32'(rsp_quot), 32'h0);
        check_eq("reset_rsp_divz", 32'(rsp_divz), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_div_den", 32'(div_den), 32'h1);
        do_reset();

        // ---- Single op: port 2, 1000/7 ----
        next_cycle();
        req_valid = '0;
        set_req(2, 32'd1000, 22'd7);
        settle();
        check_eq("single_ready", 32'(req_ready), 32'h4);
        check_eq("single_div_num", div_num, 32'd1000);
        check_eq("single_div_den", 32'(div_den), 32'd7);
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            req_valid = '0;
            settle();
            if (c == 1) check_eq("single_busy", 32'(busy), 32'h1);
            if (c == 6) begin
                check_eq("single_rsp_valid", 32'(rsp_valid), 32'h4);
                check_eq("single_rsp_quot", 32'(rsp_quot), 32'd142);
                check_eq("single_rsp_divz", 32'(rsp_divz), 32'h0);
            end else begin
                check_eq("single_no_strobe", 32'(rsp_valid), 32'h0);
            end
        end

        // ---- Round robin: all ports valid for 8 cycles from rr_ptr=0 ----
        do_reset();
        rr_exp[0] = 20'd333;  // 1000/3
        rr_exp[1] = 20'd500;  // 2000/4
        rr_exp[2] = 20'd600;  // 3000/5
        rr_exp[3] = 20'd666;  // 4000/6
        for (int c = 0; c <= 14; c++) begin
            next_cycle();
            req_valid = '0;
            if (c < 8) begin
                for (int p = 0; p < 4; p++) set_req(p, 32'(1000 * (p + 1)), 22'(p + 3));
            end
            settle();
            if (c < 8) check_eq("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 6 && c < 14) begin
                check_eq("rr_rsp_valid", 32'(rsp_valid), 32'(1 << ((c - 6) % 4)));
                check_eq("rr_rsp_quot", 32'(rsp_quot), 32'(rr_exp[(c - 6) % 4]));
            end else begin
                check_eq("rr_no_strobe", 32'(rsp_valid), 32'h0);
            end
        end

        // ---- Divide by zero: 500/0 then -500/0 ----
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            req_valid = '0;
            if (c == 0) set_req(0, 32'd500, 22'd0);
            if (c == 1) set_req(1, -32'sd500, 22'd0);
            settle();
            if (c >= 2) check_eq("divz_idle_den", 32'(div_den), 32'h1);
            if (c == 6) begin
                check_eq("divz_pos_valid", 32'(rsp_valid), 32'h1);
                check_eq("divz_pos_quot", 32'(rsp_quot), 32'h7FFFF);
                check_eq("divz_pos_flag", 32'(rsp_divz), 32'h1);
            end
            if (c == 7) begin
                check_eq("divz_neg_valid", 32'(rsp_valid), 32'h2);
                check_eq("divz_neg_quot", 32'(rsp_quot), 32'h80000);
                check_eq("divz_neg_flag", 32'(rsp_divz), 32'h1);
            end
        end

        // ---- Signed quotients and truncation ----
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            req_valid = '0;
            if (c == 0) set_req(3, -32'sd1000, 22'd7);
            if (c == 1) set_req(0, 32'd1000, 22'h3FFFF9);   // 1000 / -7
            if (c == 2) set_req(1, 32'h7FFFFFFF, 22'd1);    // low 20 bits only
            settle();
            if (c == 6) begin
                check_eq("sgn_nn_valid", 32'(rsp_valid), 32'h8);
                check_eq("sgn_nn_quot", 32'(rsp_quot), 32'hFFF72);
                check_eq("sgn_nn_divz", 32'(rsp_divz), 32'h0);
            end
            if (c == 7) begin
                check_eq("sgn_nd_valid", 32'(rsp_valid), 32'h1);
                check_eq("sgn_nd_quot", 32'(rsp_quot), 32'hFFF72);
            end
            if (c == 8) begin
                check_eq("trunc_valid", 32'(rsp_valid), 32'h2);
                check_eq("trunc_quot", 32'(rsp_quot), 32'hFFFFF);
            end
        end

        // ---- Flush: ops at 0..3, flush at 4, new op at 5 ----
        for (int c = 0; c <= 12; c++) begin
            next_cycle();
            req_valid = '0;
            flush     = 1'b0;
            if (c < 4) set_req(c, 32'(1000 * (c + 1)), 22'(c + 3));
            if (c == 4) begin
                flush     = 1'b1;
                req_valid = 4'b1111;
            end
            if (c == 5) set_req(1, 32'd70, 22'd7);
            settle();
            if (c == 4) check_eq("flush_no_grant", 32'(req_ready), 32'h0);
            if (c == 5) check_eq("flush_busy_clear", 32'(busy), 32'h0);
            if (c >= 5 && c <= 10) check_eq("flush_no_strobe", 32'(rsp_valid), 32'h0);
            if (c == 11) begin
                check_eq("flush_new_valid", 32'(rsp_valid), 32'h2);
                check_eq("flush_new_quot", 32'(rsp_quot), 32'd10);
            end
        end
        flush = 1'b0;

        // ---- Asynchronous reset with three ops in flight ----
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            req_valid = '0;
            set_req(c, 32'd777, 22'd3);
            settle();
        end
        next_cycle();
        req_valid = 4'b1111;
        check_eq("arst_busy_before", 32'(busy), 32'h1);
        check_eq("arst_quot_before", 32'(rsp_quot), 32'd10);
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_ready", 32'(req_ready), 32'h0);
        check_eq("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("arst_rsp_quot", 32'(rsp_quot), 32'h0);
        check_eq("arst_rsp_divz", 32'(rsp_divz), 32'h0);
        check_eq("arst_busy", 32'(busy), 32'h0);
        check_eq("arst_div_num", div_num, 32'h0);
        next_cycle();
        next_cycle();
        rst       = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            settle();
            check_eq("arst_no_rsp", 32'(rsp_valid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
